// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - parametrised LCD panel timing generator (counters, panel strobes, pixel enable)
module lcd_timing_gen #(
    parameter int H_BITS   = 9,
    parameter int V_BITS   = 8,
    parameter int H_TOTAL  = 456,
    parameter int H_START  = 80,
    parameter int H_ACTIVE = 160,
    parameter int V_TOTAL  = 154,
    parameter int V_ACTIVE = 144,
    parameter int ST_WIDTH = 1,
    parameter int FR_MODE  = 0,
    parameter int FR_LINES = 13
) (
    input  logic              clk2,
    input  logic              reset_video,
    input  logic              lcd_en,
    input  logic              div_cpl,
    input  logic              div_fr,
    input  logic              pix_stall,
    output logic [H_BITS-1:0] hcnt,
    output logic [V_BITS-1:0] vcnt,
    output logic              pix_ce,
    output logic              line_start,
    output logic              frame_start,
    output logic              overrun,
    output logic              pin_cpl,
    output logic              pin_fr,
    output logic              pin_st,
    output logic              pin_s
);
    localparam int PX_W = $clog2(H_ACTIVE + 1);
    localparam int ST_W = $clog2(ST_WIDTH + 1);
    localparam int FL_W = $clog2(FR_LINES + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PIXELS, S_BLANK} state_t;

    state_t            r_state, w_state_n;
    logic [H_BITS-1:0] r_hcnt, w_hcnt_n;
    logic [V_BITS-1:0] r_vcnt, w_vcnt_n;
    logic [PX_W-1:0]   r_px, w_px_n;
    logic [ST_W-1:0]   r_st_left, w_st_left_n;
    logic [FL_W-1:0]   r_frcnt, w_frcnt_n;
    logic              r_pix_ce, w_pix_ce_n;
    logic              r_line_start, w_line_start_n;
    logic              r_frame_start, w_frame_start_n;
    logic              r_overrun, w_overrun_n;
    logic              r_pin_cpl, w_pin_cpl_n;
    logic              r_pin_fr, w_pin_fr_n;
    logic              r_pin_st, w_pin_st_n;
    logic              r_pin_s, w_pin_s_n;
    logic              w_line_end, w_frame_end, w_last_px, w_enabled_n;

    always_comb begin
        w_line_end  = (r_hcnt == H_BITS'(H_TOTAL - 1));
        w_frame_end = w_line_end && (r_vcnt == V_BITS'(V_TOTAL - 1));
        w_last_px   = r_pix_ce && (r_px == PX_W'(H_ACTIVE - 1));

        w_state_n   = r_state;
        w_hcnt_n    = r_hcnt;
        w_vcnt_n    = r_vcnt;
        w_px_n      = r_px;
        w_overrun_n = r_overrun;
        w_pin_fr_n  = r_pin_fr;
        w_frcnt_n   = r_frcnt;

        if (!lcd_en) begin
            w_state_n   = S_IDLE;
            w_hcnt_n    = '0;
            w_vcnt_n    = '0;
            w_px_n      = '0;
            w_overrun_n = 1'b0;
            w_frcnt_n   = '0;
            w_pin_fr_n  = div_fr;
        end else if (r_state == S_IDLE) begin
            w_state_n  = S_FETCH;
            w_hcnt_n   = '0;
            w_vcnt_n   = '0;
            w_px_n     = '0;
            w_frcnt_n  = '0;
            w_pin_fr_n = 1'b0;
        end else if (w_line_end) begin
            w_hcnt_n  = '0;
            w_vcnt_n  = w_frame_end ? '0 : r_vcnt + V_BITS'(1);
            w_px_n    = '0;
            w_state_n = (w_vcnt_n < V_BITS'(V_ACTIVE)) ? S_FETCH : S_BLANK;
            // A final pixel landing on the last clock still completes the line.
            if (r_state == S_PIXELS && !w_last_px) begin
                w_overrun_n = 1'b1;
            end
            if (FR_MODE == 0) begin
                if (w_frame_end) begin
                    w_pin_fr_n = !r_pin_fr;
                end
            end else if (w_frame_end) begin
                w_frcnt_n = '0;
            end else if (r_frcnt == FL_W'(FR_LINES - 1)) begin
                w_frcnt_n  = '0;
                w_pin_fr_n = !r_pin_fr;
            end else begin
                w_frcnt_n = r_frcnt + FL_W'(1);
            end
        end else begin
            w_hcnt_n = r_hcnt + H_BITS'(1);
            case (r_state)
                S_FETCH: begin
                    if (r_hcnt == H_BITS'(H_START - 1)) begin
                        w_state_n = S_PIXELS;
                    end
                end
                S_PIXELS: begin
                    if (w_last_px) begin
                        w_state_n = S_BLANK;
                        w_px_n    = '0;
                    end else if (r_pix_ce) begin
                        w_px_n = r_px + PX_W'(1);
                    end
                end
                default: ;
            endcase
        end

        w_enabled_n     = (w_state_n != S_IDLE);
        w_pix_ce_n      = (w_state_n == S_PIXELS) && !pix_stall;
        w_line_start_n  = w_enabled_n && (w_hcnt_n == '0);
        w_frame_start_n = w_line_start_n && (w_vcnt_n == '0);
        w_pin_s_n       = w_enabled_n && (w_vcnt_n == '0);
        w_pin_cpl_n     = w_enabled_n ? (w_hcnt_n == '0) : div_cpl;

        // The ST window is a free-running countdown so stalls cannot stretch it.
        w_pin_st_n  = 1'b0;
        w_st_left_n = '0;
        if (w_enabled_n) begin
            if (w_pix_ce_n && w_px_n == '0) begin
                w_pin_st_n  = 1'b1;
                w_st_left_n = ST_W'(ST_WIDTH - 1);
            end else if (r_st_left != '0) begin
                w_pin_st_n  = 1'b1;
                w_st_left_n = r_st_left - ST_W'(1);
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (reset_video) begin
            r_state       <= S_IDLE;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_px          <= '0;
            r_st_left     <= '0;
            r_frcnt       <= '0;
            r_pix_ce      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
            r_pin_cpl     <= 1'b0;
            r_pin_fr      <= 1'b0;
            r_pin_st      <= 1'b0;
            r_pin_s       <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_hcnt        <= w_hcnt_n;
            r_vcnt        <= w_vcnt_n;
            r_px          <= w_px_n;
            r_st_left     <= w_st_left_n;
            r_frcnt       <= w_frcnt_n;
            r_pix_ce      <= w_pix_ce_n;
            r_line_start  <= w_line_start_n;
            r_frame_start <= w_frame_start_n;
            r_overrun     <= w_overrun_n;
            r_pin_cpl     <= w_pin_cpl_n;
            r_pin_fr      <= w_pin_fr_n;
            r_pin_st      <= w_pin_st_n;
            r_pin_s       <= w_pin_s_n;
        end
    end

    assign hcnt        = r_hcnt;
    assign vcnt        = r_vcnt;
    assign pix_ce      = r_pix_ce;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign overrun     = r_overrun;
    assign pin_cpl     = r_pin_cpl;
    assign pin_fr      = r_pin_fr;
    assign pin_st      = r_pin_st;
    assign pin_s       = r_pin_s;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - scoreboard bench for lcd_timing_gen against a line/frame arithmetic model
module tb_lcd_timing_gen;
    localparam int HT = 20, HS = 4, HA = 8, VT = 6, VA = 4, SW = 2, FL = 4;

    logic       clk2 = 1'b0;
    logic       reset_video = 1'b1, lcd_en = 1'b0, div_cpl = 1'b0, div_fr = 1'b0, pix_stall = 1'b0;
    logic [8:0] hcnt0, hcnt1;
    logic [7:0] vcnt0, vcnt1;
    logic       pix0, ls0, fs0, ovr0, cpl0, fr0, st0, s0;
    logic       pix1, ls1, fs1, ovr1, cpl1, fr1, st1, s1;

    always #5 clk2 = !clk2;

    lcd_timing_gen #(.H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
                     .ST_WIDTH(SW), .FR_MODE(0), .FR_LINES(FL)) dut0 (
        .clk2(clk2), .reset_video(reset_video), .lcd_en(lcd_en), .div_cpl(div_cpl), .div_fr(div_fr),
        .pix_stall(pix_stall), .hcnt(hcnt0), .vcnt(vcnt0), .pix_ce(pix0), .line_start(ls0),
        .frame_start(fs0), .overrun(ovr0), .pin_cpl(cpl0), .pin_fr(fr0), .pin_st(st0), .pin_s(s0));

    lcd_timing_gen #(.H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
                     .ST_WIDTH(SW), .FR_MODE(1), .FR_LINES(FL)) dut1 (
        .clk2(clk2), .reset_video(reset_video), .lcd_en(lcd_en), .div_cpl(div_cpl), .div_fr(div_fr),
        .pix_stall(pix_stall), .hcnt(hcnt1), .vcnt(vcnt1), .pix_ce(pix1), .line_start(ls1),
        .frame_start(fs1), .overrun(ovr1), .pin_cpl(cpl1), .pin_fr(fr1), .pin_st(st1), .pin_s(s1));

    typedef struct packed {
        logic [8:0] h;
        logic [7:0] v;
        logic pix, ls, fs, ovr, cpl, fra, frb, st, s;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, n_mon = 0;

    // Reference model: position in the line/frame plus pixels emitted so far this line.
    bit   m_en = 0, m_pix = 0, m_ovr = 0, m_base = 0;
    int   m_h = 0, m_v = 0, m_px = 0, m_frames = 0, m_cyc = 0, m_first = -1000;
    int   burst_left = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (monitor cycle %0d)", name, act, exp, n_mon);
        end
    endtask

    function automatic bit pick_stall(input int mode, input int h, input int v);
        bit r;
        r = 1'b0;
        if (mode == 1) begin
            r = (v == 1 && (h == 6 || h == 7)) || (v == 2 && h >= 4);
        end else if (mode == 2) begin
            if (burst_left > 0) begin
                burst_left--;
                r = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                burst_left = int'($urandom_range(8, 20));
                r = 1'b1;
            end else begin
                r = ($urandom_range(0, 3) == 0);
            end
        end
        return r;
    endfunction

    task automatic step(input bit rst, input bit en, input int smode, input bit dc, input bit df);
        exp_t e;
        bit   stall;
        e = '0;
        stall = 1'(($urandom_range(0, 1)));
        if (rst) begin
            m_en = 0; m_h = 0; m_v = 0; m_px = 0; m_ovr = 0; m_pix = 0; m_first = -1000;
        end else if (!en) begin
            m_en = 0; m_h = 0; m_v = 0; m_px = 0; m_ovr = 0; m_pix = 0; m_first = -1000;
            e.cpl = dc;
            e.fra = df;
            e.frb = df;
        end else begin
            if (!m_en) begin
                m_en = 1; m_h = 0; m_v = 0; m_px = 0; m_frames = 0; m_base = 0;
            end else begin
                if (m_pix) m_px++;
                if (m_h == HT - 1) begin
                    if (m_v < VA && m_px < HA) m_ovr = 1;
                    m_h = 0;
                    m_px = 0;
                    if (m_v == VT - 1) begin
                        m_v = 0;
                        m_frames++;
                        m_base = m_base ^ 1'(((VT - 1) / FL) & 1);
                    end else begin
                        m_v++;
                    end
                end else begin
                    m_h++;
                end
            end
            stall = pick_stall(smode, m_h, m_v);
            m_pix = (m_v < VA) && (m_h >= HS) && (m_px < HA) && !stall;
            if (m_pix && m_px == 0) m_first = m_cyc;
            e.h   = 9'(m_h);
            e.v   = 8'(m_v);
            e.pix = m_pix;
            e.ls  = (m_h == 0);
            e.fs  = (m_h == 0) && (m_v == 0);
            e.cpl = (m_h == 0);
            e.s   = (m_v == 0);
            e.ovr = m_ovr;
            e.st  = (m_cyc - m_first >= 0) && (m_cyc - m_first < SW);
            e.fra = 1'(m_frames & 1);
            e.frb = m_base ^ 1'((m_v / FL) & 1);
        end
        reset_video = rst;
        lcd_en      = en;
        div_cpl     = dc;
        div_fr      = df;
        pix_stall   = stall;
        q.push_back(e);
        m_cyc++;
        @(posedge clk2);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk2);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_mon++;
                chk("hcnt", int'(hcnt0), int'(e.h));
                chk("vcnt", int'(vcnt0), int'(e.v));
                chk("pix_ce", int'(pix0), int'(e.pix));
                chk("line_start", int'(ls0), int'(e.ls));
                chk("frame_start", int'(fs0), int'(e.fs));
                chk("overrun", int'(ovr0), int'(e.ovr));
                chk("pin_cpl", int'(cpl0), int'(e.cpl));
                chk("pin_fr_mode0", int'(fr0), int'(e.fra));
                chk("pin_st", int'(st0), int'(e.st));
                chk("pin_s", int'(s0), int'(e.s));
                chk("m1_hcnt", int'(hcnt1), int'(e.h));
                chk("m1_vcnt", int'(vcnt1), int'(e.v));
                chk("m1_pix_ce", int'(pix1), int'(e.pix));
                chk("m1_line_start", int'(ls1), int'(e.ls));
                chk("m1_frame_start", int'(fs1), int'(e.fs));
                chk("m1_overrun", int'(ovr1), int'(e.ovr));
                chk("m1_pin_cpl", int'(cpl1), int'(e.cpl));
                chk("pin_fr_mode1", int'(fr1), int'(e.frb));
                chk("m1_pin_st", int'(st1), int'(e.st));
                chk("m1_pin_s", int'(s1), int'(e.s));
            end
        end
    end

    initial begin : stimulus
        int  guard;
        int  off_left;
        int  r;
        bit  rst_b, en_b;
        off_left = 0;

        // Reset for 3 clocks, the last with lcd_en already high.
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 1, 0, 1, 1);
        // Three frames with the directed stall pattern (short stall line 1, full stall line 2).
        for (int i = 0; i < 3 * HT * VT; i++) step(0, 1, 1, 0, 0);
        // Three clean frames for FR sequencing.
        for (int i = 0; i < 3 * HT * VT; i++) step(0, 1, 0, 0, 0);
        // Abort at line 2 hcnt 7.
        guard = 0;
        while (!(m_h == 7 && m_v == 2) && guard < 500) begin
            step(0, 1, 0, 0, 0);
            guard++;
        end
        chk("abort_point_reached", guard < 500 ? 1 : 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        // Re-enable, then reset while enabled mid-frame and release.
        for (int i = 0; i < 57; i++) step(0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 0, 1);
        for (int i = 0; i < 2 * HT * VT; i++) step(0, 1, 2, 0, 0);
        // Randomised phase: stalls, bursts, disables and resets.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            rst_b = (r < 2);
            if (off_left > 0) begin
                en_b = 0;
                off_left--;
            end else if (r >= 2 && r < 6) begin
                en_b = 0;
                off_left = int'($urandom_range(0, 5));
            end else begin
                en_b = 1;
            end
            step(rst_b, en_b, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        #10;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
